// File: rtl/pipe_stage_latch_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_latch_if
// Brief    : Upstream/downstream valid-ready bus of a pipeline stage latch.
// Revision : 1.0
// ============================================================================
interface pipe_stage_latch_if #(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 6
) ();
    logic               i_valid;
    logic [NB_PC-1:0]   i_pc;
    logic [NB_DATA-1:0] i_data;
    logic               o_ready;
    logic               o_valid;
    logic [NB_PC-1:0]   o_pc;
    logic [NB_DATA-1:0] o_data;
    logic               i_ready;

    // master: the environment around the latch (producer and consumer)
    modport master (
        output i_valid, i_pc, i_data, i_ready,
        input  o_ready, o_valid, o_pc, o_data
    );

    modport slave (
        input  i_valid, i_pc, i_data, i_ready,
        output o_ready, o_valid, o_pc, o_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_latch.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_latch
// Brief    : Generic pipeline-stage latch with 2-entry skid buffer, flush,
//            step credits, EOF halt, retire counter and debug snapshot.
// Revision : 1.0
// ============================================================================
module pipe_stage_latch #(
    parameter int                 NB_DATA     = 32,
    parameter int                 NB_PC       = 6,
    parameter int                 NB_STEP     = 8,
    parameter int                 NB_CNT      = 16,
    parameter logic [NB_DATA-1:0] EOF_PATTERN = 32'h69656F66,
    parameter int                 DBG_SIZE    = NB_DATA + NB_PC + 5
) (
    input  wire logic                i_clk,
    input  wire logic                i_reset_n,
    pipe_stage_latch_if.slave        bus,
    input  wire logic                i_flush,
    input  wire logic [1:0]          i_mode,
    input  wire logic                i_step_pulse,
    input  wire logic [NB_STEP-1:0]  i_step_count,
    input  wire logic                i_clear_halt,
    output logic                     o_eof,
    output logic                     o_halted,
    output logic [NB_STEP-1:0]       o_step_credit,
    output logic [NB_CNT-1:0]        o_retired,
    output logic [DBG_SIZE-1:0]      o_dbg_data
);

    localparam logic [1:0] c_MODE_CONT = 2'b01;
    localparam logic [1:0] c_MODE_STEP = 2'b11;

    logic                main_valid_q, main_valid_d;
    logic [NB_PC-1:0]    main_pc_q,    main_pc_d;
    logic [NB_DATA-1:0]  main_data_q,  main_data_d;
    logic                main_eof_q,   main_eof_d;
    logic                skid_valid_q, skid_valid_d;
    logic [NB_PC-1:0]    skid_pc_q,    skid_pc_d;
    logic [NB_DATA-1:0]  skid_data_q,  skid_data_d;
    logic                skid_eof_q,   skid_eof_d;
    logic                halted_q,     halted_d;
    logic [NB_STEP-1:0]  credit_q,     credit_d;
    logic [NB_CNT-1:0]   retired_q,    retired_d;
    logic [DBG_SIZE-1:0] dbg_q,        dbg_d;

    logic               w_enable;
    logic               w_accept;
    logic               w_step_acc;
    logic               w_in_eof;
    logic               w_out_fire;
    logic [NB_STEP-1:0] w_load;

    assign w_in_eof   = (bus.i_data == EOF_PATTERN);
    assign w_enable   = !halted_q && ((i_mode == c_MODE_CONT) ||
                                      ((i_mode == c_MODE_STEP) && (credit_q != '0)));
    assign w_accept   = bus.i_valid && !skid_valid_q && w_enable && !i_flush;
    assign w_step_acc = w_accept && (i_mode == c_MODE_STEP);
    assign w_out_fire = main_valid_q && bus.i_ready && !i_flush;
    assign w_load     = (i_step_count == '0) ? NB_STEP'(1) : i_step_count;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_data_d  = main_data_q;
        main_eof_d   = main_eof_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_data_d  = skid_data_q;
        skid_eof_d   = skid_eof_q;
        halted_d     = halted_q;
        credit_d     = credit_q;
        retired_d    = retired_q;
        dbg_d        = dbg_q;

        // Flush dominates the skid move and the downstream handshake.
        if (i_flush) begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_data_d  = '0;
            main_eof_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // A valid skid implies main is valid; it refills main on handshake.
            if (bus.i_ready) begin
                main_valid_d = 1'b1;
                main_pc_d    = skid_pc_q;
                main_data_d  = skid_data_q;
                main_eof_d   = skid_eof_q;
                skid_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (!main_valid_q || bus.i_ready) begin
                main_valid_d = 1'b1;
                main_pc_d    = bus.i_pc;
                main_data_d  = bus.i_data;
                main_eof_d   = w_in_eof;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = bus.i_pc;
                skid_data_d  = bus.i_data;
                skid_eof_d   = w_in_eof;
            end
        end else if (w_out_fire) begin
            main_valid_d = 1'b0;
        end

        if (w_accept && w_in_eof) begin
            halted_d = 1'b1;
        end else if (i_clear_halt) begin
            halted_d = 1'b0;
        end

        if (i_step_pulse) begin
            credit_d = w_load - {{(NB_STEP-1){1'b0}}, w_step_acc};
        end else if (w_step_acc && (credit_q != '0)) begin
            credit_d = credit_q - NB_STEP'(1);
        end

        if (w_out_fire) begin
            retired_d = retired_q + NB_CNT'(1);
        end

        if (w_accept || i_flush) begin
            dbg_d = {halted_q, w_in_eof, i_mode, i_flush, bus.i_pc, bus.i_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= '0;
            main_data_q  <= '0;
            main_eof_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_data_q  <= '0;
            skid_eof_q   <= 1'b0;
            halted_q     <= 1'b0;
            credit_q     <= '0;
            retired_q    <= '0;
            dbg_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_data_q  <= main_data_d;
            main_eof_q   <= main_eof_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_data_q  <= skid_data_d;
            skid_eof_q   <= skid_eof_d;
            halted_q     <= halted_d;
            credit_q     <= credit_d;
            retired_q    <= retired_d;
            dbg_q        <= dbg_d;
        end
    end

    assign bus.o_ready    = !skid_valid_q;
    assign bus.o_valid    = main_valid_q;
    assign bus.o_pc       = main_pc_q;
    assign bus.o_data     = main_data_q;
    assign o_eof          = main_valid_q && main_eof_q;
    assign o_halted       = halted_q;
    assign o_step_credit  = credit_q;
    assign o_retired      = retired_q;
    assign o_dbg_data     = dbg_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_latch
// Brief    : Self-checking bench for pipe_stage_latch (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_latch;
    localparam int NB_DATA  = 32;
    localparam int NB_PC    = 6;
    localparam int NB_STEP  = 8;
    localparam int NB_CNT   = 16;
    localparam int DBG_SIZE = NB_DATA + NB_PC + 5;
    localparam logic [31:0] c_EOF = 32'h69656F66;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               flush, pulse, clr;
    logic [1:0]         mode;
    logic [NB_STEP-1:0] scount;
    logic               eof, halted;
    logic [NB_STEP-1:0] credit;
    logic [NB_CNT-1:0]  retired;
    logic [DBG_SIZE-1:0] dbg;

    pipe_stage_latch_if #(.NB_DATA(NB_DATA), .NB_PC(NB_PC)) bus ();

    pipe_stage_latch #(
        .NB_DATA(NB_DATA), .NB_PC(NB_PC), .NB_STEP(NB_STEP), .NB_CNT(NB_CNT),
        .EOF_PATTERN(c_EOF), .DBG_SIZE(DBG_SIZE)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus),
        .i_flush(flush), .i_mode(mode), .i_step_pulse(pulse),
        .i_step_count(scount), .i_clear_halt(clr),
        .o_eof(eof), .o_halted(halted), .o_step_credit(credit),
        .o_retired(retired), .o_dbg_data(dbg)
    );

    typedef struct packed {
        logic [NB_PC-1:0]   pc;
        logic [NB_DATA-1:0] data;
    } item_t;

    typedef struct {
        int v, pc, rdy, acc, ev, epc, erdy;
    } vec_t;

    item_t sb_q[$];
    vec_t  vt[12];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB_DATA-1:0] pat(input int pc);
        return 32'hA500_0000 + 32'(pc);
    endfunction

    task automatic drive(input logic v, input int pc, input logic [NB_DATA-1:0] d, input logic push);
        item_t it;
        bus.i_valid = v;
        bus.i_pc    = NB_PC'(pc);
        bus.i_data  = d;
        if (push) begin
            it.pc   = NB_PC'(pc);
            it.data = d;
            sb_q.push_back(it);
        end
    endtask

    // Consumes the handshake about to happen, then advances one clock.
    task automatic tick();
        item_t e;
        if (bus.o_valid && bus.i_ready && !flush) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_extra: got pc %0d expected nothing", bus.o_pc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", 64'(bus.o_pc), 64'(e.pc));
                chk("sb_data", 64'(bus.o_data), 64'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NB_CNT-1:0] r_save;

        vt[0]  = '{1, 0, 1, 1, 1, 0, 1};
        vt[1]  = '{1, 1, 1, 1, 1, 1, 1};
        vt[2]  = '{1, 2, 1, 1, 1, 2, 1};
        vt[3]  = '{1, 3, 1, 1, 1, 3, 1};
        vt[4]  = '{0, 0, 1, 0, 0, 0, 1};
        vt[5]  = '{1, 0, 0, 1, 1, 0, 1};
        vt[6]  = '{1, 1, 0, 1, 1, 0, 0};
        vt[7]  = '{1, 2, 0, 0, 1, 0, 0};
        vt[8]  = '{1, 2, 0, 0, 1, 0, 0};
        vt[9]  = '{1, 2, 1, 0, 1, 1, 1};
        vt[10] = '{1, 2, 1, 1, 1, 2, 1};
        vt[11] = '{0, 0, 1, 0, 0, 0, 1};

        flush = 1'b0; pulse = 1'b0; clr = 1'b0; mode = 2'b01; scount = '0;
        bus.i_valid = 1'b0; bus.i_pc = '0; bus.i_data = '0; bus.i_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   64'(bus.o_valid), 64'd0);
        chk("rst_ready",   64'(bus.o_ready), 64'd1);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_dbg",     64'(dbg), 64'd0);
        chk("rst_halted",  64'(halted), 64'd0);
        rst_n = 1'b1;

        // Streaming and back-pressure vectors
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].v[0], vt[i].pc, pat(vt[i].pc), vt[i].acc[0]);
            bus.i_ready = vt[i].rdy[0];
            tick();
            chk("vec_valid", 64'(bus.o_valid), 64'(vt[i].ev));
            if (vt[i].ev != 0) chk("vec_pc", 64'(bus.o_pc), 64'(vt[i].epc));
            chk("vec_ready", 64'(bus.o_ready), 64'(vt[i].erdy));
            if (i == 4) chk("retired_4", 64'(retired), 64'd4);
        end
        chk("retired_7", 64'(retired), 64'd7);

        // Step mode: credit of 3 against 5 offers
        mode = 2'b11;
        drive(1'b0, 0, '0, 1'b0);
        pulse = 1'b1; scount = 8'd3;
        tick();
        pulse = 1'b0;
        chk("credit_load3", 64'(credit), 64'd3);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16 + k, pat(16 + k), k < 3);
            tick();
            chk("credit_dec", 64'(credit), 64'((k < 3) ? (2 - k) : 0));
        end
        chk("step_ready", 64'(bus.o_ready), 64'd1);
        drive(1'b0, 0, '0, 1'b0);
        tick();

        // Zero count behaves as one
        pulse = 1'b1; scount = 8'd0;
        tick();
        pulse = 1'b0;
        chk("credit_load0", 64'(credit), 64'd1);
        drive(1'b1, 24, pat(24), 1'b1);
        tick();
        drive(1'b1, 24, pat(24), 1'b0);
        tick();
        chk("credit_after0", 64'(credit), 64'd0);
        drive(1'b0, 0, '0, 1'b0);
        tick();

        // Pulse coinciding with an accept
        pulse = 1'b1; scount = 8'd1;
        tick();
        scount = 8'd4;
        drive(1'b1, 25, pat(25), 1'b1);
        tick();
        pulse = 1'b0;
        chk("credit_coinc", 64'(credit), 64'd3);
        drive(1'b0, 0, '0, 1'b0);
        tick();

        // Frozen mode accepts nothing; continuous holds credit
        mode = 2'b00;
        drive(1'b1, 26, pat(26), 1'b0);
        tick();
        tick();
        chk("freeze_valid", 64'(bus.o_valid), 64'd0);
        mode = 2'b01;
        drive(1'b1, 27, pat(27), 1'b1);
        tick();
        chk("cont_credit", 64'(credit), 64'd3);

        // EOF halt and release
        drive(1'b1, 5, c_EOF, 1'b1);
        tick();
        chk("eof_flag", 64'(eof), 64'd1);
        chk("eof_pc", 64'(bus.o_pc), 64'd5);
        chk("eof_halted", 64'(halted), 64'd1);
        chk("eof_dbg", 64'(dbg[DBG_SIZE-2]), 64'd1);
        drive(1'b1, 6, pat(6), 1'b0);
        tick();
        chk("halt_block1", 64'(bus.o_valid), 64'd0);
        tick();
        chk("halt_block2", 64'(bus.o_valid), 64'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("halt_clear", 64'(halted), 64'd0);
        chk("halt_clear_v", 64'(bus.o_valid), 64'd0);
        drive(1'b1, 6, pat(6), 1'b1);
        tick();
        chk("post_halt_pc", 64'(bus.o_pc), 64'd6);
        chk("post_halt_eof", 64'(eof), 64'd0);
        drive(1'b1, 7, c_EOF, 1'b1);
        clr = 1'b1;
        tick();
        chk("eof_beats_clear", 64'(halted), 64'd1);
        drive(1'b0, 0, '0, 1'b0);
        tick();
        clr = 1'b0;
        chk("clear_again", 64'(halted), 64'd0);

        // Flush with both entries full
        bus.i_ready = 1'b0;
        drive(1'b1, 8, pat(8), 1'b1);
        tick();
        drive(1'b1, 9, pat(9), 1'b1);
        tick();
        chk("full_ready", 64'(bus.o_ready), 64'd0);
        r_save = retired;
        bus.i_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 10, pat(10), 1'b0);
        tick();
        flush = 1'b0;
        sb_q.delete();
        drive(1'b0, 0, '0, 1'b0);
        chk("flush_valid", 64'(bus.o_valid), 64'd0);
        chk("flush_data", 64'(bus.o_data), 64'd0);
        chk("flush_ready", 64'(bus.o_ready), 64'd1);
        chk("flush_retired", 64'(retired), 64'(r_save));
        chk("flush_dbg_bit", 64'(dbg[NB_DATA+NB_PC]), 64'd1);
        chk("flush_dbg_pc", 64'(dbg[NB_DATA +: NB_PC]), 64'd10);
        tick();
        chk("flush_dropped", 64'(bus.o_valid), 64'd0);

        // Asynchronous reset between edges
        drive(1'b1, 11, pat(11), 1'b1);
        tick();
        drive(1'b1, 12, pat(12), 1'b1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("arst_valid",   64'(bus.o_valid), 64'd0);
        chk("arst_data",    64'(bus.o_data), 64'd0);
        chk("arst_ready",   64'(bus.o_ready), 64'd1);
        chk("arst_retired", 64'(retired), 64'd0);
        chk("arst_credit",  64'(credit), 64'd0);
        chk("arst_dbg",     64'(dbg), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 13, pat(13), 1'b1);
        tick();
        chk("post_rst_valid", 64'(bus.o_valid), 64'd1);
        chk("post_rst_pc", 64'(bus.o_pc), 64'd13);
        drive(1'b0, 0, '0, 1'b0);
        tick();
        chk("post_rst_retired", 64'(retired), 64'd1);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
- Parametrised successor to the fixed-width IF/ID latch, for use between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an NB_DATA payload plus NB_PC program counter with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under downstream back-pressure.
- Adds flush, continuous/step modes with a multi-step credit counter, EOF halt, a retire counter and a debug snapshot bus.

Parameters:
- NB_DATA, 32, payload width.
- NB_PC, 6, program counter width.
- NB_STEP, 8, step-credit width.
- NB_CNT, 16, retire-counter width.
- EOF_PATTERN, 32'h69656F66 ("ieof"), payload value marking end of program; width NB_DATA.
- DBG_SIZE, NB_DATA+NB_PC+5, debug snapshot width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream payload valid.
- i_pc  in  NB_PC  upstream PC.
- i_data  in  NB_DATA  upstream payload.
- o_ready  out  1  latch can accept (registered).
- o_valid  out  1  output payload valid.
- o_pc  out  NB_PC  output PC.
- o_data  out  NB_DATA  output payload.
- i_ready  in  1  downstream accepts.
- i_flush  in  1  synchronous flush of both entries.
- i_mode  in  2  2'b01 continuous, 2'b11 step, other values freeze input acceptance.
- i_step_pulse  in  1  load step credit.
- i_step_count  in  NB_STEP  credit to load; 0 is treated as 1.
- i_clear_halt  in  1  clears EOF halt.
- o_eof  out  1  current output entry is EOF.
- o_halted  out  1  EOF accepted, input blocked.
- o_step_credit  out  NB_STEP  remaining credit.
- o_retired  out  NB_CNT  count of output handshakes.
- o_dbg_data  out  DBG_SIZE  snapshot {halted, eof, mode[1:0], flush, pc, data} of the last accept/flush.

Behaviour:
- Reset (i_reset_n=0, async): both entries invalid. o_valid=0, o_pc=0, o_data=0, o_eof=0, o_halted=0, o_step_credit=0, o_retired=0, o_dbg_data=0, o_ready=1.
- enable = !halted && (mode==01 || (mode==11 && credit!=0)).
- accept = i_valid && o_ready && enable && !i_flush.
- Entries: main drives the outputs; skid holds an overflow entry. o_ready = !skid_valid.
- On accept with main empty, or with main valid && i_ready: the payload goes to main.
- On accept with main valid && !i_ready: the payload goes to skid.
- When skid is valid and i_ready: skid moves to main, skid is cleared.
- Latency is one cycle from accept to o_valid. Throughput is 1 per cycle while i_ready=1.
- Output is held stable while o_valid && !i_ready.
- EOF flag: stored per entry as (data==EOF_PATTERN). o_eof is main's flag.
- Halt: accepting an EOF sets halted next cycle; entries already buffered still drain. i_clear_halt clears halted. If an EOF accept and i_clear_halt coincide, halted is set.
- Step credit: i_step_pulse loads max(i_step_count,1). Each accept in step mode decrements credit, saturating at 0. A pulse coinciding with an accept loads max(count,1)-1. In continuous mode the credit is held.
- Flush: both entries invalid next cycle; o_data/o_pc forced to 0; o_eof=0. Input presented during the flush cycle is dropped. Credit and halted are unaffected. Flush overrides a simultaneous skid-to-main move and downstream handshake, so no retire is counted.
- Retire: o_retired increments on o_valid && i_ready && !i_flush and wraps modulo 2^NB_CNT.
- Debug: o_dbg_data updates on any accept or flush cycle with the input-side values and flags of that cycle; otherwise it holds.
- Mode change mid-stream affects only future accepts; buffered entries still drain.
- Reset asserted mid-transfer discards everything immediately.

Test Plan:
- Continuous, i_ready=1, 4 payloads PC 0..3 back-to-back -> o_valid one cycle later for each, in order; o_retired=4; o_ready stays 1.
- i_ready=0 for 3 cycles while streaming PC 0,1,2 -> main holds PC0; skid takes PC1; o_ready=0 and PC2 is held upstream. On i_ready=1, outputs PC0,1,2 in order with no loss or duplication.
- Step mode, i_step_pulse with count=3, 5 payloads offered -> exactly 3 accepted, credit 3→0, o_ready=1 but no further accepts. count=0 pulse -> exactly 1 accept.
- Payload 32'h69656F66 at PC 5 followed by PC 6 -> o_eof=1 with PC5 output; o_halted=1; PC6 not accepted until i_clear_halt, then accepted.
- i_flush while main and skid are both full and i_valid=1 -> next cycle o_valid=0, o_data=0, o_ready=1, retire unchanged; o_dbg_data flush bit=1 with that cycle's i_pc.
- i_reset_n low asynchronously mid-stream between clock edges -> all outputs go to reset values immediately; after release, the first accept behaves as on the empty latch.
